// File: rtl/bus_demux_pkg.sv
// Shared configuration for the cpu memory-bus demultiplexer: default address map,
// timeout and the FSM state type.
package bus_demux_pkg;

   localparam int DEF_SLAVES = 3;

   // Element 0 is the rightmost entry: slave0 = bram, slave1 = uart, slave2 = timer.
   localparam logic [2:0][31:0] DEF_BASE = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
   localparam logic [2:0][31:0] DEF_MASK = {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFF00_0000};

   localparam int BUS_TIMEOUT = 256;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_ERR
   } bus_state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bus_demux_addr_decode.sv
// Priority address decoder: reports whether the address falls in any slave window
// and, if so, the lowest-numbered matching slave.
module addr_decode
   import bus_demux_pkg::*;
#(
   parameter int                      SLAVES = DEF_SLAVES,
   parameter logic [SLAVES-1:0][31:0] BASE   = DEF_BASE,
   parameter logic [SLAVES-1:0][31:0] MASK   = DEF_MASK,
   localparam int                     IDX_W  = idx_width(SLAVES)
) (
   input  logic [31:0]      addr,
   output logic             hit,
   output logic [IDX_W-1:0] idx
);

   // Scan from the top down so the lowest matching index is the one left standing.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = SLAVES - 1; i >= 0; i--) begin
         if ((addr & MASK[i]) == (BASE[i] & MASK[i])) begin
            hit = 1'b1;
            idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/bus_demux.sv
// One-master / N-slave memory bus interconnect with a single outstanding transaction,
// decode-error and timeout-error responses.
module bus_demux
   import bus_demux_pkg::*;
#(
   parameter int                      SLAVES  = DEF_SLAVES,
   parameter logic [SLAVES-1:0][31:0] BASE    = DEF_BASE,
   parameter logic [SLAVES-1:0][31:0] MASK    = DEF_MASK,
   parameter int                      TIMEOUT = BUS_TIMEOUT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     memory_valid,
   input  logic                     memory_instr,
   input  logic [31:0]              memory_addr,
   input  logic [31:0]              memory_wdata,
   input  logic [3:0]               memory_wstrb,
   output logic [31:0]              memory_rdata,
   output logic                     memory_ready,
   output logic                     memory_error,
   output logic [SLAVES-1:0]        slave_valid,
   output logic                     slave_instr,
   output logic [31:0]              slave_addr,
   output logic [31:0]              slave_wdata,
   output logic [3:0]               slave_wstrb,
   input  logic [SLAVES-1:0][31:0]  slave_rdata,
   input  logic [SLAVES-1:0]        slave_ready,
   output logic [31:0]              err_addr
);

   localparam int IDX_W = idx_width(SLAVES);
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   bus_state_t       state, state_nxt;
   logic             hit;
   logic [IDX_W-1:0] hit_idx;
   logic [IDX_W-1:0] sel_q;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      addr_q;
   logic             accept;
   logic             expire;

   addr_decode #(
      .SLAVES (SLAVES),
      .BASE   (BASE),
      .MASK   (MASK)
   ) u_decode (
      .addr (memory_addr),
      .hit  (hit),
      .idx  (hit_idx)
   );

   assign slave_instr = memory_instr;
   assign slave_addr  = memory_addr;
   assign slave_wdata = memory_wdata;
   assign slave_wstrb = memory_wstrb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      slave_valid  = '0;
      memory_ready = 1'b0;
      memory_error = 1'b0;
      memory_rdata = '0;
      accept       = 1'b0;
      expire       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (memory_valid) begin
               if (hit) begin
                  slave_valid[hit_idx] = 1'b1;
                  accept               = 1'b1;
                  if (slave_ready[hit_idx]) begin
                     memory_ready = 1'b1;
                     memory_rdata = slave_rdata[hit_idx];
                  end else begin
                     state_nxt = ST_BUSY;
                  end
               end else begin
                  state_nxt = ST_ERR;
               end
            end
         end
         ST_BUSY: begin
            memory_rdata = slave_rdata[sel_q];
            if (slave_ready[sel_q]) begin
               memory_ready = 1'b1;
               state_nxt    = ST_IDLE;
            end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
               expire    = 1'b1;
               state_nxt = ST_ERR;
            end
         end
         ST_ERR: begin
            memory_ready = 1'b1;
            memory_error = 1'b1;
            state_nxt    = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      // Hold every strobe quiet while reset is asserted, even if the cpu keeps driving.
      if (rst) begin
         slave_valid  = '0;
         memory_ready = 1'b0;
         memory_error = 1'b0;
         memory_rdata = '0;
         accept       = 1'b0;
         expire       = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q    <= '0;
         cnt_q    <= '0;
         err_addr <= '0;
      end else begin
         if (accept) sel_q <= hit_idx;
         if (state == ST_IDLE)                           cnt_q <= '0;
         else if (state == ST_BUSY && !slave_ready[sel_q]) cnt_q <= cnt_q + 1'b1;
         if (state == ST_IDLE && memory_valid && !hit) err_addr <= memory_addr;
         else if (expire)                               err_addr <= addr_q;
      end
   end

   // Request address kept for reporting a timed-out access.
   always_ff @(posedge clk) begin
      if (accept) addr_q <= memory_addr;
   end

endmodule

// File: tb/tb_bus_demux.sv
// Directed bench for bus_demux: a table of single-access vectors plus hand-written
// multi-cycle sequences for latency, timeout, stray responses and reset.
module tb_bus_demux;
   import bus_demux_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   logic             memory_valid;
   logic             memory_instr;
   logic [31:0]      memory_addr;
   logic [31:0]      memory_wdata;
   logic [3:0]       memory_wstrb;
   logic [31:0]      memory_rdata;
   logic             memory_ready;
   logic             memory_error;
   logic [2:0]       slave_valid;
   logic             slave_instr;
   logic [31:0]      slave_addr;
   logic [31:0]      slave_wdata;
   logic [3:0]       slave_wstrb;
   logic [2:0][31:0] slave_rdata;
   logic [2:0]       slave_ready;
   logic [31:0]      err_addr;

   int total  = 0;
   int passed = 0;

   bus_demux #(
      .SLAVES  (3),
      .BASE    (DEF_BASE),
      .MASK    (DEF_MASK),
      .TIMEOUT (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .memory_valid (memory_valid),
      .memory_instr (memory_instr),
      .memory_addr  (memory_addr),
      .memory_wdata (memory_wdata),
      .memory_wstrb (memory_wstrb),
      .memory_rdata (memory_rdata),
      .memory_ready (memory_ready),
      .memory_error (memory_error),
      .slave_valid  (slave_valid),
      .slave_instr  (slave_instr),
      .slave_addr   (slave_addr),
      .slave_wdata  (slave_wdata),
      .slave_wstrb  (slave_wstrb),
      .slave_rdata  (slave_rdata),
      .slave_ready  (slave_ready),
      .err_addr     (err_addr)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, got running expected finished");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [2:0]  rdy;
      logic [2:0]  sv;
      logic        ready;
      logic [31:0] rdata;
      logic        err_next;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Drive at the falling edge and let combinational outputs settle before sampling.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      vecs[0] = '{32'h0000_0040, 4'b0000, 3'b001, 3'b001, 1'b1, 32'h1111_1111, 1'b0};
      vecs[1] = '{32'h1000_0004, 4'b0001, 3'b010, 3'b010, 1'b1, 32'h2222_2222, 1'b0};
      vecs[2] = '{32'h2000_000C, 4'b1111, 3'b100, 3'b100, 1'b1, 32'h3333_3333, 1'b0};
      vecs[3] = '{32'h00FF_FFFC, 4'b0000, 3'b001, 3'b001, 1'b1, 32'h1111_1111, 1'b0};
      vecs[4] = '{32'h1000_0010, 4'b0011, 3'b111, 3'b000, 1'b0, 32'h0000_0000, 1'b1};
      vecs[5] = '{32'h3000_0000, 4'b0000, 3'b000, 3'b000, 1'b0, 32'h0000_0000, 1'b1};

      rst          = 1'b1;
      memory_valid = 1'b0;
      memory_instr = 1'b0;
      memory_addr  = '0;
      memory_wdata = 32'h5A5A_A5A5;
      memory_wstrb = '0;
      slave_ready  = '0;
      slave_rdata  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

      step(); settle();
      chk("reset_ready", {31'd0, memory_ready}, 32'd0);
      chk("reset_error", {31'd0, memory_error}, 32'd0);
      chk("reset_rdata", memory_rdata, 32'd0);
      chk("reset_slave_valid", {29'd0, slave_valid}, 32'd0);
      chk("reset_err_addr", err_addr, 32'd0);
      step();
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         step();
         memory_valid = 1'b1;
         memory_addr  = vecs[i].addr;
         memory_wstrb = vecs[i].wstrb;
         slave_ready  = vecs[i].rdy;
         settle();
         chk($sformatf("vec%0d_slave_valid", i), {29'd0, slave_valid}, {29'd0, vecs[i].sv});
         chk($sformatf("vec%0d_ready", i), {31'd0, memory_ready}, {31'd0, vecs[i].ready});
         chk($sformatf("vec%0d_error", i), {31'd0, memory_error}, 32'd0);
         chk($sformatf("vec%0d_rdata", i), memory_rdata, vecs[i].rdata);
         chk($sformatf("vec%0d_wstrb_bcast", i), {28'd0, slave_wstrb}, {28'd0, vecs[i].wstrb});
         step();
         memory_valid = 1'b0;
         slave_ready  = '0;
         settle();
         chk($sformatf("vec%0d_next_ready", i), {31'd0, memory_ready}, {31'd0, vecs[i].err_next});
         chk($sformatf("vec%0d_next_error", i), {31'd0, memory_error}, {31'd0, vecs[i].err_next});
         if (vecs[i].err_next) begin
            chk($sformatf("vec%0d_err_rdata", i), memory_rdata, 32'd0);
            chk($sformatf("vec%0d_err_addr", i), err_addr, vecs[i].addr);
         end
      end

      // Read to slave0 answered two cycles after the request.
      step();
      memory_valid = 1'b1;
      memory_addr  = 32'h0000_0040;
      memory_wstrb = 4'b0000;
      settle();
      chk("lat_sv_c0", {29'd0, slave_valid}, 32'b001);
      chk("lat_ready_c0", {31'd0, memory_ready}, 32'd0);
      step(); settle();
      chk("lat_sv_c1", {29'd0, slave_valid}, 32'd0);
      chk("lat_ready_c1", {31'd0, memory_ready}, 32'd0);
      step();
      slave_ready    = 3'b001;
      slave_rdata[0] = 32'hCAFE_BABE;
      settle();
      chk("lat_ready_c2", {31'd0, memory_ready}, 32'd1);
      chk("lat_rdata_c2", memory_rdata, 32'hCAFE_BABE);
      chk("lat_error_c2", {31'd0, memory_error}, 32'd0);
      step();
      memory_valid = 1'b0;
      slave_ready  = '0;

      // Timeout on slave2: error at cycle 5, late ready at cycle 7 ignored.
      step();
      memory_valid = 1'b1;
      memory_addr  = 32'h2000_0000;
      settle();
      chk("to_sv_c0", {29'd0, slave_valid}, 32'b100);
      for (int c = 1; c <= 4; c++) begin
         step(); settle();
         chk($sformatf("to_ready_c%0d", c), {31'd0, memory_ready}, 32'd0);
      end
      step(); settle();
      chk("to_ready_c5", {31'd0, memory_ready}, 32'd1);
      chk("to_error_c5", {31'd0, memory_error}, 32'd1);
      chk("to_rdata_c5", memory_rdata, 32'd0);
      chk("to_err_addr_c5", err_addr, 32'h2000_0000);
      chk("to_sv_c5", {29'd0, slave_valid}, 32'd0);
      step();
      memory_valid = 1'b0;
      settle();
      chk("to_ready_c6", {31'd0, memory_ready}, 32'd0);
      step();
      slave_ready = 3'b100;
      settle();
      chk("to_late_ready_c7", {31'd0, memory_ready}, 32'd0);
      chk("to_late_error_c7", {31'd0, memory_error}, 32'd0);
      step();
      slave_ready = '0;

      // Stray ready from slave0 while slave1 owns the bus.
      step();
      memory_valid = 1'b1;
      memory_addr  = 32'h1000_0000;
      settle();
      chk("stray_sv_c0", {29'd0, slave_valid}, 32'b010);
      step();
      slave_ready = 3'b001;
      settle();
      chk("stray_ready_c1", {31'd0, memory_ready}, 32'd0);
      step(); settle();
      chk("stray_ready_c2", {31'd0, memory_ready}, 32'd0);
      step();
      slave_ready    = 3'b010;
      slave_rdata[1] = 32'h1234_5678;
      settle();
      chk("stray_ready_c3", {31'd0, memory_ready}, 32'd1);
      chk("stray_rdata_c3", memory_rdata, 32'h1234_5678);
      step();
      memory_valid = 1'b0;
      slave_ready  = '0;

      // Reset pulse while BUSY, then a late slave response and a fresh read.
      step();
      memory_valid = 1'b1;
      memory_addr  = 32'h0000_0100;
      step();
      memory_valid = 1'b0;
      rst          = 1'b1;
      settle();
      chk("rst_ready_during", {31'd0, memory_ready}, 32'd0);
      chk("rst_err_addr", err_addr, 32'd0);
      rst = 1'b0;
      step();
      slave_ready = 3'b001;
      settle();
      chk("rst_late_ready", {31'd0, memory_ready}, 32'd0);
      chk("rst_late_rdata", memory_rdata, 32'd0);
      chk("rst_late_sv", {29'd0, slave_valid}, 32'd0);
      step();
      slave_ready  = '0;
      memory_valid = 1'b1;
      memory_addr  = 32'h0000_0200;
      settle();
      chk("rst_new_sv", {29'd0, slave_valid}, 32'b001);
      step();
      slave_ready    = 3'b001;
      slave_rdata[0] = 32'hDEAD_BEEF;
      settle();
      chk("rst_new_ready", {31'd0, memory_ready}, 32'd1);
      chk("rst_new_rdata", memory_rdata, 32'hDEAD_BEEF);
      step();
      memory_valid = 1'b0;
      slave_ready  = '0;
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
